// File: rtl/step_clock_controller.sv
// step_clock_controller: turns the board step button or a free-run rate timer into a shaped cpu_clk pulse plus a one-cycle step_en strobe.
// Latency: 1 clk from an accepted step request to the cpu_clk rising edge and step_en; key presses add 2 sync + DEBOUNCE_CYCLES.
// Backpressure: none; requests arriving while a pulse is in flight are dropped. Optional macro BREAKPOINT_EN adds halt-on-PC in free-run.
module step_clock_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HIGH_CYCLES     = 4,
  parameter int unsigned RATE_BASE       = 5000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_n,
  input  logic        run_mode,
  input  logic [1:0]  rate_sel,
  input  logic [31:0] pc_value,
  input  logic [31:0] bp_addr,
  output logic        cpu_clk,
  output logic        step_en,
  output logic [31:0] step_count,
  output logic        halted
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = (HIGH_CYCLES > 1) ? $clog2(HIGH_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HIGH_CYCLES - 1);
  localparam logic [31:0]   RATE_BASE_W = 32'(RATE_BASE);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  // ---------------- key synchroniser and debounce ----------------
  logic          sync1_q, sync2_q;
  logic          db_q, db_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          press;

  // Two-flop synchroniser; resets to the released level so reset never looks like a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new key level only after it has differed from the debounced level for DEBOUNCE_CYCLES cycles in a row.
  always_comb begin
    db_d   = db_q;
    dcnt_d = '0;
    press  = 1'b0;
    if (sync2_q != db_q) begin
      if (dcnt_q == DB_LAST) begin
        db_d  = sync2_q;
        press = ~sync2_q;
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_q   <= 1'b1;
      dcnt_q <= '0;
    end else begin
      db_q   <= db_d;
      dcnt_q <= dcnt_d;
    end
  end

  // ---------------- free-run rate timer ----------------
  logic [1:0]  rate_sel_q;
  logic [31:0] rcnt_q, rcnt_d;
  logic [31:0] period_shr, period_last;
  logic        rate_chg, rate_hit;

  // A rate_sel change restarts the period; the tick is withheld on that cycle because the count belongs to the old rate.
  always_comb begin
    period_shr  = RATE_BASE_W >> {rate_sel, 1'b0};
    period_last = (period_shr == 32'd0) ? 32'd0 : period_shr - 32'd1;
    rate_chg    = (rate_sel != rate_sel_q);
    rate_hit    = run_mode && !rate_chg && (rcnt_q == period_last);
    if (!run_mode || rate_chg || rate_hit) begin
      rcnt_d = '0;
    end else begin
      rcnt_d = rcnt_q + 32'd1;
    end
  end

  // Rate timer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rate_sel_q <= 2'd0;
      rcnt_q     <= '0;
    end else begin
      rate_sel_q <= rate_sel;
      rcnt_q     <= rcnt_d;
    end
  end

  // ---------------- pulse FSM ----------------
  logic [1:0]    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          done;
  logic          req, accept;
  logic          run_block, press_ok;
  logic          cpu_clk_q, step_en_q;
  logic [31:0]   count_q;

  // The final LOW cycle completes the step.
  assign done = (state_q == ST_LOW) && (hold_q == HOLD_LAST);

`ifdef BREAKPOINT_EN
  logic halted_q, halted_d;
  logic bp_hit;

  assign bp_hit = run_mode && done && (pc_value == bp_addr);

  // Halt when a free-run step completes on the breakpoint PC; a press or leaving free-run releases it.
  always_comb begin
    halted_d = halted_q;
    if (!run_mode || press) begin
      halted_d = 1'b0;
    end else if (bp_hit) begin
      halted_d = 1'b1;
    end
  end

  // Halt flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  assign run_block = halted_q | bp_hit;
  assign press_ok  = ~run_mode | halted_q;
  assign halted    = halted_q;
`else
  logic unused_bp;

  assign unused_bp = ^{pc_value, bp_addr};
  assign run_block = 1'b0;
  assign press_ok  = ~run_mode;
  assign halted    = 1'b0;
`endif

  assign req = (press & press_ok) | (rate_hit & ~run_block);

  // IDLE waits for a request; HIGH and LOW each last HIGH_CYCLES. The last LOW cycle may start the next step directly,
  // which makes the step period floor exactly 2*HIGH_CYCLES.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          accept  = 1'b1;
          state_d = ST_HIGH;
          hold_d  = '0;
        end
      end
      ST_HIGH: begin
        if (hold_q == HOLD_LAST) begin
          state_d = ST_LOW;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      ST_LOW: begin
        if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          if (req) begin
            accept  = 1'b1;
            state_d = ST_HIGH;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = '0;
      end
    endcase
  end

  // FSM and registered outputs; the async reset drops cpu_clk immediately even mid-pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      cpu_clk_q <= 1'b0;
      step_en_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      cpu_clk_q <= (state_d == ST_HIGH);
      step_en_q <= accept;
      if (accept) begin
        count_q <= count_q + 32'd1;
      end
    end
  end

  assign cpu_clk    = cpu_clk_q;
  assign step_en    = step_en_q;
  assign step_count = count_q;

endmodule

// File: tb/tb_step_clock_controller.sv
// Bench for step_clock_controller with DEBOUNCE_CYCLES=8, HIGH_CYCLES=2, RATE_BASE=64.
// Table of free-run rate cases, directed key/reset/breakpoint sequences, and a random run against a reference model.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_step_clock_controller;

  localparam int DB = 8;
  localparam int HC = 2;
  localparam int RB = 64;

  logic        clk, reset, key_n, run_mode;
  logic [1:0]  rate_sel;
  logic [31:0] pc_value, bp_addr;
  logic        cpu_clk, step_en, halted;
  logic [31:0] step_count;

  int errors = 0;
  int checks = 0;

  step_clock_controller #(
    .DEBOUNCE_CYCLES(DB),
    .HIGH_CYCLES    (HC),
    .RATE_BASE      (RB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_n     (key_n),
    .run_mode  (run_mode),
    .rate_sel  (rate_sel),
    .pc_value  (pc_value),
    .bp_addr   (bp_addr),
    .cpu_clk   (cpu_clk),
    .step_en   (step_en),
    .step_count(step_count),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Works from the behavioural rules: key seen through a 2-cycle delay, a level is accepted once the last
  // DB delayed samples all agree on a new value, free-run ticks are periodic from the last restart, and a
  // step is issued when a request arrives at least 2*HC edges after the previous rising edge.
  logic        mk_key[$];
  logic        m_sync[$];
  logic        m_db;
  logic [1:0]  m_prev_rs;
  int          m_c, m_last_clear, m_last_rise;
  logic [31:0] m_cnt;

  function automatic void model_reset();
    mk_key.delete();
    m_sync.delete();
    m_db         = 1'b1;
    m_prev_rs    = 2'd0;
    m_c          = 0;
    m_last_clear = 0;
    m_last_rise  = -1000;
    m_cnt        = 32'd0;
  endfunction

  task automatic model_cycle(input logic k, input logic rm, input logic [1:0] rs,
                             output logic e_clk, output logic e_en, output logic [31:0] e_cnt);
    logic s, press, rreq, req, chg, same;
    int   p, edge_i;
    mk_key.push_back(k);
    s = (m_c >= 2) ? mk_key[m_c-2] : 1'b1;
    m_sync.push_back(s);
    press = 1'b0;
    if (m_c >= DB - 1 && s != m_db) begin
      same = 1'b1;
      for (int i = 0; i < DB; i++) if (m_sync[m_c-i] != s) same = 1'b0;
      if (same) begin
        press = (s == 1'b0);
        m_db  = s;
      end
    end
    chg = (rs != m_prev_rs);
    p   = RB >> (2 * int'(rs));
    if (p == 0) p = 1;
    rreq = rm && !chg && (((m_c - m_last_clear) % p) == p - 1);
    if (!rm || chg) m_last_clear = m_c + 1;
    req    = rm ? rreq : press;
    edge_i = m_c + 1;
    if (req && (edge_i - m_last_rise) >= 2 * HC) begin
      m_last_rise = edge_i;
      m_cnt++;
    end
    e_clk     = (edge_i - m_last_rise) < HC;
    e_en      = (edge_i == m_last_rise);
    e_cnt     = m_cnt;
    m_prev_rs = rs;
    m_c++;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    key_n    = 1'b1;
    run_mode = 1'b0;
    rate_sel = 2'd0;
    pc_value = 32'd0;
    bp_addr  = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    check("reset_cpu_clk", 32'(cpu_clk), 32'd0);
    check("reset_step_en", 32'(step_en), 32'd0);
    check("reset_count", step_count, 32'd0);
    check("reset_halted", 32'(halted), 32'd0);
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------- free-run table ----------------
  // rate_sel resets to 0, so a non-zero rate_sel at reset release counts as a change and delays the first tick by one.
  typedef struct {
    logic       rm;
    logic [1:0] rs;
    int         ncyc;
    int         exp_steps;
    int         exp_first;
    int         exp_gap;
    int         exp_hirun;
  } rate_vec_t;

  rate_vec_t tbl[5];

  initial begin
    int n, first, prev, gmin, gmax, hirun, run, g;
    logic        e_clk, e_en;
    logic [31:0] e_cnt;
    logic        rk, rrm;
    logic [1:0]  rrs;
    int          hold;

    tbl[0] = '{1'b1, 2'd0, 640, 10, 64, 64, HC};
    tbl[1] = '{1'b1, 2'd1, 161, 10, 17, 16, HC};
    tbl[2] = '{1'b1, 2'd2,  41, 10,  5,  4, HC};
    tbl[3] = '{1'b1, 2'd3,  41, 10,  2,  4, HC};
    tbl[4] = '{1'b0, 2'd0,  50,  0,  0,  0, 0};

    for (int t = 0; t < 5; t++) begin
      do_reset();
      run_mode = tbl[t].rm;
      rate_sel = tbl[t].rs;
      n = 0; first = 0; prev = 0; gmin = 0; gmax = 0; hirun = 0; run = 0;
      for (int e = 1; e <= tbl[t].ncyc; e++) begin
        step();
        if (step_en) begin
          n++;
          if (first == 0) first = e;
          else begin
            g = e - prev;
            if (gmin == 0 || g < gmin) gmin = g;
            if (g > gmax) gmax = g;
          end
          prev = e;
        end
        run = cpu_clk ? run + 1 : 0;
        if (run > hirun) hirun = run;
      end
      check($sformatf("tbl%0d_steps", t), 32'(n), 32'(tbl[t].exp_steps));
      check($sformatf("tbl%0d_count", t), step_count, 32'(tbl[t].exp_steps));
      check($sformatf("tbl%0d_first", t), 32'(first), 32'(tbl[t].exp_first));
      check($sformatf("tbl%0d_gapmin", t), 32'(gmin), 32'(tbl[t].exp_gap));
      check($sformatf("tbl%0d_gapmax", t), 32'(gmax), 32'(tbl[t].exp_gap));
      check($sformatf("tbl%0d_hirun", t), 32'(hirun), 32'(tbl[t].exp_hirun));
    end

    // ---- single press: key low 20 cycles, step 10 edges after the first low sample ----
    do_reset();
    n = 0; first = 0; hirun = 0;
    for (int e = 1; e <= 40; e++) begin
      key_n = (e <= 20) ? 1'b0 : 1'b1;
      step();
      if (step_en) begin n++; if (first == 0) first = e; end
      if (cpu_clk) hirun++;
    end
    check("press_steps", 32'(n), 32'd1);
    check("press_edge", 32'(first), 32'd10);
    check("press_high_cycles", 32'(hirun), 32'(HC));
    check("press_count", step_count, 32'd1);

    // ---- bouncing key, then stable low, then release ----
    do_reset();
    n = 0; first = 0; prev = 0;
    for (int c = 0; c < 100; c++) begin
      if (c < 30) key_n = ((c / 3) % 2 == 0) ? 1'b0 : 1'b1;
      else if (c < 60) key_n = 1'b0;
      else key_n = 1'b1;
      step();
      if (step_en) begin
        n++;
        if (first == 0) first = c + 1;
        if (c + 1 < 40) prev++;
      end
    end
    check("bounce_early_steps", 32'(prev), 32'd0);
    check("bounce_first_edge", 32'(first), 32'd40);
    check("bounce_total_steps", 32'(n), 32'd1);
    check("bounce_count", step_count, 32'd1);

    // ---- reset asserted while cpu_clk is high ----
    do_reset();
    run_mode = 1'b1;
    rate_sel = 2'd3;
    n = 0;
    while (!cpu_clk && n < 20) begin step(); n++; end
    check("rst_mid_seen_high", 32'(cpu_clk), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_cpu_clk", 32'(cpu_clk), 32'd0);
    check("rst_mid_step_en", 32'(step_en), 32'd0);
    check("rst_mid_count", step_count, 32'd0);
    run_mode = 1'b0;
    rate_sel = 2'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    n = 0; hirun = 0;
    for (int e = 0; e < 30; e++) begin
      step();
      if (step_en) n++;
      if (cpu_clk) hirun++;
    end
    check("rst_after_steps", 32'(n), 32'd0);
    check("rst_after_high", 32'(hirun), 32'd0);

`ifdef BREAKPOINT_EN
    // ---- breakpoint: pc advances by 4 per step, halt when the completed step leaves pc at 0x8 ----
    do_reset();
    bp_addr  = 32'h8;
    pc_value = 32'h0;
    run_mode = 1'b1;
    rate_sel = 2'd3;
    for (int e = 0; e < 40; e++) begin
      step();
      if (step_en) pc_value = pc_value + 32'd4;
      if (halted) break;
    end
    check("bp_halted", 32'(halted), 32'd1);
    check("bp_count", step_count, 32'd2);
    check("bp_pc", pc_value, 32'h8);
    n = 0;
    for (int e = 0; e < 20; e++) begin
      step();
      if (step_en) n++;
    end
    check("bp_no_more_steps", 32'(n), 32'd0);
    check("bp_still_halted", 32'(halted), 32'd1);
    key_n = 1'b0;
    n = 0;
    while (!step_en && n < 30) begin step(); n++; end
    check("bp_press_step", 32'(step_en), 32'd1);
    check("bp_press_count", step_count, 32'd3);
    check("bp_press_clears", 32'(halted), 32'd0);
    key_n = 1'b1;
`endif

    // ---- random run against the reference model ----
    do_reset();
    rk = 1'b1; rrm = 1'b0; rrs = 2'd0; hold = 5;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        rk   = ~rk;
        hold = $urandom_range(14, 1);
      end else begin
        hold--;
      end
      if ($urandom_range(149, 0) == 0) rrm = ~rrm;
      if ($urandom_range(99, 0) == 0) rrs = 2'($urandom_range(3, 0));
      key_n    = rk;
      run_mode = rrm;
      rate_sel = rrs;
      model_cycle(rk, rrm, rrs, e_clk, e_en, e_cnt);
      step();
      check($sformatf("rand_flags@%0d", c), 32'({cpu_clk, step_en, halted}), 32'({e_clk, e_en, 1'b0}));
      check($sformatf("rand_count@%0d", c), step_count, e_cnt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
